// File: rtl/z80_bus_fabric.sv
// z80_bus_fabric: CPU-side bus fabric between the tv80s core and N peripheral
// slots. Latches the winning slot at access start, inserts per-slot wait
// states, honours slave ready and returns DEFAULT_DATA for unmapped reads.
// Optional feature macro: BUS_TIMEOUT_EN (forces completion of hung slaves
// after TIMEOUT consecutive HOLD cycles and raises a sticky bus error).
module z80_bus_fabric #(
  parameter int                N_SLOTS      = 8,
  parameter int                DATA_W       = 8,
  parameter int                WAIT_W       = 4,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 8'hFF,
  parameter int                TIMEOUT      = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        mreq_n,
  input  logic                        ioreq_n,
  input  logic                        rd_n,
  input  logic                        wr_n,
  output logic [DATA_W-1:0]           cpu_data_o,
  output logic                        wait_n_o,
  input  logic [N_SLOTS-1:0]          slot_cs_i,
  input  logic [N_SLOTS*DATA_W-1:0]   slot_data_i,
  input  logic [N_SLOTS-1:0]          slot_ready_i,
  input  logic [N_SLOTS*WAIT_W-1:0]   wait_cfg_i,
  output logic [N_SLOTS-1:0]          slot_stb_o,
  input  logic                        err_clr_i,
  output logic                        bus_err_o,
  output logic [3:0]                  err_slot_o
);

  localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_act_q;
  logic                r_is_rd;
  logic [SLOT_W-1:0]   r_slot_q;
  logic [WAIT_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_act;
  logic                w_start;
  logic                w_mapped;
  logic [SLOT_W-1:0]   w_sel;
  logic [SLOT_W-1:0]   w_dsel;
  logic [WAIT_W-1:0]   w_cfg;
  logic [DATA_W-1:0]   w_slot_data;
  logic                w_ready;
  logic                w_timeout;
  logic                w_rd_xfer;

  // A start is the first cycle of an active strobe pair seen from IDLE.
  assign w_act    = (~mreq_n | ~ioreq_n) & (~rd_n | ~wr_n);
  assign w_start  = (r_state == ST_IDLE) & w_act & ~r_act_q & ~rst_i;
  assign w_mapped = |slot_cs_i;

  // Lowest-index chip select wins when several are asserted.
  always_comb begin
    w_sel = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (slot_cs_i[k]) begin
        w_sel = SLOT_W'(k);
      end
    end
  end

  // In the start cycle the live decode selects the slot; afterwards the latched one.
  assign w_dsel      = (r_state == ST_IDLE) ? w_sel : r_slot_q;
  assign w_slot_data = slot_data_i[w_dsel*DATA_W +: DATA_W];
  assign w_cfg       = wait_cfg_i[w_sel*WAIT_W +: WAIT_W];
  assign w_ready     = slot_ready_i[w_dsel];
  assign w_rd_xfer   = w_start ? ~rd_n : r_is_rd;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_bus_err;
  logic [3:0]      r_err_slot;

  // The forcing cycle is the TIMEOUT-th consecutive HOLD cycle without ready.
  assign w_timeout = (r_state == ST_HOLD) & w_act & ~w_ready &
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Count consecutive HOLD cycles; set the sticky error with priority over clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt   <= '0;
      r_bus_err  <= 1'b0;
      r_err_slot <= '0;
    end else begin
      if (r_state != ST_HOLD) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_timeout) begin
        r_bus_err  <= 1'b1;
        r_err_slot <= 4'(r_slot_q);
      end else if (err_clr_i) begin
        r_bus_err <= 1'b0;
      end
    end
  end

  assign bus_err_o  = r_bus_err;
  assign err_slot_o = r_err_slot;
`else
  logic w_unused;

  assign w_timeout  = 1'b0;
  assign bus_err_o  = 1'b0;
  assign err_slot_o = 4'd0;
  assign w_unused   = err_clr_i ^ (TIMEOUT == 0);
`endif

  // Next-state decode; abort on strobe release takes precedence in WAIT/HOLD.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (!w_mapped) begin
            w_next = ST_DONE;
          end else if (w_cfg != '0) begin
            w_next = ST_WAIT;
          end else if (!w_ready) begin
            w_next = ST_HOLD;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (!w_act) begin
          w_next = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_next = w_ready ? ST_DONE : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!w_act) begin
          w_next = ST_IDLE;
        end else if (w_ready || w_timeout) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!w_act) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The CPU is held only while the access will still be pending next cycle,
  // so the completing cycle already releases wait_n.
  assign wait_n_o = rst_i | ~((w_next == ST_WAIT) | (w_next == ST_HOLD));

  assign slot_stb_o = (w_start && w_mapped) ? (N_SLOTS'(1) << w_sel) : '0;

  // Read data: live slot data while in flight, captured data once done.
  always_comb begin
    cpu_data_o = DEFAULT_DATA;
    case (r_state)
      ST_WAIT, ST_HOLD: cpu_data_o = w_slot_data;
      ST_DONE:          cpu_data_o = r_rdata;
      default: begin
        if (w_start && w_mapped) begin
          cpu_data_o = w_slot_data;
        end
      end
    endcase
  end

  // State register, access latches, wait counter and read-data capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_act_q  <= 1'b1;
      r_is_rd  <= 1'b0;
      r_slot_q <= '0;
      r_cnt    <= '0;
      r_rdata  <= DEFAULT_DATA;
    end else begin
      r_state <= w_next;
      r_act_q <= w_act;
      if (w_start) begin
        r_slot_q <= w_sel;
        r_is_rd  <= ~rd_n;
        r_cnt    <= w_cfg - WAIT_W'(1);
      end else if (r_state == ST_WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - WAIT_W'(1);
      end
      if (w_next == ST_DONE && r_state != ST_DONE) begin
        if (w_timeout) begin
          r_rdata <= DEFAULT_DATA;
        end else if (w_rd_xfer) begin
          r_rdata <= (w_start && !w_mapped) ? DEFAULT_DATA : w_slot_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_z80_bus_fabric.sv
// Testbench for z80_bus_fabric: directed scenarios plus randomized accesses
// checked against a transaction-level model (wait length = max(cfg, ready delay)).
// Build with BUS_TIMEOUT_EN defined to also exercise the timeout scenario.
module tb_z80_bus_fabric;

  localparam int         N   = 8;
  localparam int         DW  = 8;
  localparam int         WW  = 4;
  localparam logic [7:0] DEF = 8'hFF;
`ifdef BUS_TIMEOUT_EN
  localparam int         TO  = 16;
`else
  localparam int         TO  = 255;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            mreq_n, ioreq_n, rd_n, wr_n;
  logic [DW-1:0]   cpu_data_o;
  logic            wait_n_o;
  logic [N-1:0]    slot_cs_i;
  logic [N*DW-1:0] slot_data_i;
  logic [N-1:0]    slot_ready_i;
  logic [N*WW-1:0] wait_cfg_i;
  logic [N-1:0]    slot_stb_o;
  logic            err_clr_i;
  logic            bus_err_o;
  logic [3:0]      err_slot_o;

  logic [7:0]      sdata [N];
  logic [3:0]      scfg  [N];
  logic [N-1:0]    rdy_bg;
  int              rdy_slot;
  logic            rdy_now;

  int              checks   = 0;
  int              failures = 0;
  logic [7:0]      model_rdata;

  always #5 clk = ~clk;

  // Pack per-slot tables onto the flat buses and overlay the target slot's ready.
  always_comb begin
    slot_data_i  = '0;
    wait_cfg_i   = '0;
    slot_ready_i = rdy_bg;
    for (int k = 0; k < N; k++) begin
      slot_data_i[k*DW +: DW] = sdata[k];
      wait_cfg_i[k*WW +: WW]  = scfg[k];
    end
    if (rdy_slot >= 0) slot_ready_i[rdy_slot] = rdy_now;
  end

  z80_bus_fabric #(
    .N_SLOTS(N), .DATA_W(DW), .WAIT_W(WW), .DEFAULT_DATA(DEF), .TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .mreq_n(mreq_n), .ioreq_n(ioreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_data_o(cpu_data_o), .wait_n_o(wait_n_o),
    .slot_cs_i(slot_cs_i), .slot_data_i(slot_data_i), .slot_ready_i(slot_ready_i),
    .wait_cfg_i(wait_cfg_i), .slot_stb_o(slot_stb_o),
    .err_clr_i(err_clr_i), .bus_err_o(bus_err_o), .err_slot_o(err_slot_o)
  );

  function automatic int lowest(input logic [N-1:0] cs);
    int r = -1;
    for (int k = N - 1; k >= 0; k--) if (cs[k]) r = k;
    return r;
  endfunction

  // Runs one access: target ready goes high rdy_after cycles after start,
  // err_clr_i pulses in cycle clr_at. Returns observations only.
  task automatic run_access(input logic [N-1:0] cs, input bit rd, input bit io,
                            input int rdy_after, input int clr_at,
                            output int low_cnt, output logic [7:0] done_data,
                            output logic [N-1:0] stb_first, output bit stb_extra,
                            output logic [7:0] idle_data);
    int t = 0;
    bit done = 0;
    rdy_slot = lowest(cs);
    @(posedge clk); #1;
    slot_cs_i = cs;
    mreq_n    = io;
    ioreq_n   = ~io;
    rd_n      = ~rd;
    wr_n      = rd;
    rdy_now   = (rdy_after <= 0);
    err_clr_i = (clr_at == 0);
    low_cnt   = -1;
    stb_extra = 0;
    stb_first = '0;
    while (!done && t < 64) begin
      @(negedge clk);
      if (t == 0) stb_first = slot_stb_o;
      else if (slot_stb_o != '0) stb_extra = 1;
      if (wait_n_o === 1'b1) begin
        low_cnt = t;
        done    = 1;
      end
      @(posedge clk); #1;
      t++;
      rdy_now   = (t >= rdy_after);
      err_clr_i = (t == clr_at);
    end
    err_clr_i = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL access_bound: wait_n_o still low after %0d cycles, required release", t);
    end
    @(negedge clk);
    done_data = cpu_data_o;
    if (slot_stb_o != '0 || wait_n_o !== 1'b1) stb_extra = 1;
    @(posedge clk); #1;
    mreq_n = 1; ioreq_n = 1; rd_n = 1; wr_n = 1;
    slot_cs_i = '0;
    rdy_slot  = -1;
    @(posedge clk);
    @(negedge clk);
    idle_data = cpu_data_o;
  endtask

  task automatic test_reset();
    rst_i = 1; mreq_n = 1; ioreq_n = 1; rd_n = 1; wr_n = 1;
    slot_cs_i = '0; err_clr_i = 0; rdy_bg = '1; rdy_slot = -1; rdy_now = 1;
    for (int k = 0; k < N; k++) begin sdata[k] = 8'h00; scfg[k] = 4'd0; end
    repeat (3) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    checks++;
    if (wait_n_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_wait_n: got %b want 1", wait_n_o); end
    checks++;
    if (cpu_data_o !== DEF) begin failures++; $display("[TB] FAIL reset_data: got %h want %h", cpu_data_o, DEF); end
    checks++;
    if (slot_stb_o !== '0) begin failures++; $display("[TB] FAIL reset_stb: got %h want 0", slot_stb_o); end
    checks++;
    if (bus_err_o !== 1'b0 || err_slot_o !== 4'd0) begin
      failures++; $display("[TB] FAIL reset_err: got err=%b slot=%0d want 0/0", bus_err_o, err_slot_o);
    end
    model_rdata = DEF;
  endtask

  task automatic test_wait_states();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se;
    scfg[2] = 4'd3; sdata[2] = 8'h5A;
    run_access(8'h04, 1, 0, 0, -1, lc, dd, sf, se, id);
    model_rdata = 8'h5A;
    checks++;
    if (lc != 3) begin failures++; $display("[TB] FAIL wait3_len: got %0d want 3", lc); end
    checks++;
    if (dd !== 8'h5A) begin failures++; $display("[TB] FAIL wait3_data: got %h want 5a", dd); end
    checks++;
    if (sf !== 8'h04 || se) begin failures++; $display("[TB] FAIL wait3_stb: got %h extra=%0d want 04/0", sf, se); end
    checks++;
    if (id !== DEF) begin failures++; $display("[TB] FAIL wait3_idle: got %h want %h", id, DEF); end
  endtask

  task automatic test_priority();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se;
    scfg[1] = 4'd0; scfg[2] = 4'd7; sdata[1] = 8'h11; sdata[2] = 8'h22;
    run_access(8'h06, 1, 0, 0, -1, lc, dd, sf, se, id);
    model_rdata = 8'h11;
    checks++;
    if (lc != 0) begin failures++; $display("[TB] FAIL prio_len: got %0d want 0", lc); end
    checks++;
    if (dd !== 8'h11) begin failures++; $display("[TB] FAIL prio_data: got %h want 11", dd); end
    checks++;
    if (sf !== 8'h02 || se) begin failures++; $display("[TB] FAIL prio_stb: got %h extra=%0d want 02/0", sf, se); end
  endtask

  task automatic test_unmapped();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se;
    run_access('0, 1, 1, 0, -1, lc, dd, sf, se, id);
    model_rdata = DEF;
    checks++;
    if (lc != 0) begin failures++; $display("[TB] FAIL unmapped_len: got %0d want 0", lc); end
    checks++;
    if (dd !== DEF) begin failures++; $display("[TB] FAIL unmapped_data: got %h want %h", dd, DEF); end
    checks++;
    if (sf !== '0 || se) begin failures++; $display("[TB] FAIL unmapped_stb: got %h extra=%0d want 0", sf, se); end
  endtask

  task automatic test_hold();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se;
    scfg[0] = 4'd0; sdata[0] = 8'h3C;
    run_access(8'h01, 1, 0, 5, -1, lc, dd, sf, se, id);
    model_rdata = 8'h3C;
    checks++;
    if (lc != 5) begin failures++; $display("[TB] FAIL hold_len: got %0d want 5", lc); end
    checks++;
    if (dd !== 8'h3C) begin failures++; $display("[TB] FAIL hold_data: got %h want 3c", dd); end
  endtask

  task automatic test_reset_mid_wait();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se; bit bad = 0;
    scfg[3] = 4'd5; sdata[3] = 8'hA7;
    rdy_slot = 3; rdy_now = 1;
    @(posedge clk); #1;
    slot_cs_i = 8'h08; mreq_n = 0; rd_n = 0;
    @(negedge clk);
    checks++;
    if (slot_stb_o !== 8'h08 || wait_n_o !== 1'b0) begin
      failures++; $display("[TB] FAIL rstwait_start: got stb=%h wait_n=%b want 08/0", slot_stb_o, wait_n_o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1 rst_i = 1;
    @(posedge clk); #1 rst_i = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wait_n_o !== 1'b1 || slot_stb_o !== '0 || cpu_data_o !== DEF) bad = 1;
      @(posedge clk); #1;
    end
    checks++;
    if (bad) begin failures++; $display("[TB] FAIL rstwait_held: got activity while strobes held, want idle"); end
    model_rdata = DEF;
    mreq_n = 1; rd_n = 1;
    run_access(8'h08, 1, 0, 0, -1, lc, dd, sf, se, id);
    model_rdata = 8'hA7;
    checks++;
    if (sf !== 8'h08 || lc != 5 || dd !== 8'hA7) begin
      failures++; $display("[TB] FAIL rstwait_reaccess: got stb=%h len=%0d data=%h want 08/5/a7", sf, lc, dd);
    end
  endtask

  task automatic test_random();
    int lc, r, k, exp_low; logic [7:0] dd, id; logic [N-1:0] sf, cs, exp_stb; bit se, rd, io;
    for (int i = 0; i < 24; i++) begin
      for (int s = 0; s < N; s++) begin
        sdata[s] = 8'($urandom);
        scfg[s]  = 4'($urandom_range(0, 15));
      end
      rdy_bg = N'($urandom);
      cs = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      rd = 1'($urandom_range(0, 1));
      io = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 15);
      k  = lowest(cs);
      if (k < 0) begin
        exp_low = 0;
        exp_stb = '0;
        if (rd) model_rdata = DEF;
      end else begin
        exp_low = (int'(scfg[k]) > r) ? int'(scfg[k]) : r;
        exp_stb = N'(1) << k;
        if (rd) model_rdata = sdata[k];
      end
      run_access(cs, rd, io, r, -1, lc, dd, sf, se, id);
      checks++;
      if (lc != exp_low) begin failures++; $display("[TB] FAIL rand_len[%0d]: got %0d want %0d", i, lc, exp_low); end
      checks++;
      if (sf !== exp_stb || se) begin failures++; $display("[TB] FAIL rand_stb[%0d]: got %h extra=%0d want %h", i, sf, se, exp_stb); end
      checks++;
      if (dd !== model_rdata) begin failures++; $display("[TB] FAIL rand_data[%0d]: got %h want %h", i, dd, model_rdata); end
      checks++;
      if (id !== DEF) begin failures++; $display("[TB] FAIL rand_idle[%0d]: got %h want %h", i, id, DEF); end
    end
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    int lc; logic [7:0] dd, id; logic [N-1:0] sf; bit se;
    scfg[5] = 4'd0; sdata[5] = 8'h42;
    run_access(8'h20, 1, 0, 1000, -1, lc, dd, sf, se, id);
    model_rdata = DEF;
    checks++;
    if (lc != 16) begin failures++; $display("[TB] FAIL to_len: got %0d want 16", lc); end
    checks++;
    if (dd !== DEF) begin failures++; $display("[TB] FAIL to_data: got %h want %h", dd, DEF); end
    checks++;
    if (bus_err_o !== 1'b1 || err_slot_o !== 4'd5) begin
      failures++; $display("[TB] FAIL to_err: got err=%b slot=%0d want 1/5", bus_err_o, err_slot_o);
    end
    @(posedge clk); #1 err_clr_i = 1;
    @(posedge clk); #1 err_clr_i = 0;
    @(negedge clk);
    checks++;
    if (bus_err_o !== 1'b0) begin failures++; $display("[TB] FAIL to_clear: got %b want 0", bus_err_o); end
    run_access(8'h20, 1, 0, 1000, 16, lc, dd, sf, se, id);
    checks++;
    if (bus_err_o !== 1'b1) begin failures++; $display("[TB] FAIL to_set_wins: got %b want 1", bus_err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_wait_states();
    test_priority();
    test_unmapped();
    test_hold();
    test_reset_mid_wait();
    test_random();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
